vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, expected active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, expected active lines per frame.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive matching frames needed to lock.
REQ-004 SHALL have port iVGA_CLK  input  1  pixel clock; all logic on rising edge.
REQ-005 SHALL have port iRST  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port iHS  input  1  horizontal sync, active-low.
REQ-007 SHALL have port iVS  input  1  vertical sync, active-low.
REQ-008 SHALL have port iBLANK_n  input  1  data enable, high = active pixel.
REQ-009 SHALL have port iVGA_R, iVGA_G, iVGA_B  input  4 each  pixel colour.
REQ-010 SHALL have port oWR_EN  output  1  frame-buffer write strobe.
REQ-011 SHALL have port oWR_ADDR  output  19  frame-buffer write address.
REQ-012 SHALL have port oWR_DATA  output  12  {B,G,R} pixel data.
REQ-013 SHALL have port oLOCK  output  1  timing locked.
REQ-014 SHALL have port oFRAME_START  output  1  one-cycle pulse per detected frame.
REQ-015 SHALL have port oOVF  output  1  sticky per-frame address overflow flag.

Function
REQ-016 SHALL register iHS, iVS, iBLANK_n and colour in one input stage; edge detection uses input stage vs. its previous value.
REQ-017 SHALL detect frame start as iVS falling edge and line start as iHS falling edge.
REQ-018 SHALL pulse oFRAME_START for exactly one cycle, 1 cycle after the input-stage VS fall, in every state.
REQ-019 SHALL implement FSM SEARCH -> MEASURE -> LOCKED; SEARCH exits to MEASURE on first frame start.
REQ-020 SHALL, per frame, count active pixels of the current line (reset at line start) and latch it as measured width at each line's last active pixel; count lines containing >=1 active pixel as measured height; both 11-bit, saturating at 2047.
REQ-021 SHALL, in MEASURE at each frame start, increment a match counter if width==H_ACTIVE and height==V_ACTIVE, else clear it; when it reaches LOCK_FRAMES go to LOCKED.
REQ-022 SHALL, in LOCKED at each frame start, go to SEARCH and clear match counter on any width/height mismatch.
REQ-023 SHALL drive oLOCK high exactly while state is LOCKED.
REQ-024 SHALL clear write address to 0 at frame start and increment it after each active-pixel write.
REQ-025 SHALL assert oWR_EN only when state is LOCKED, input-stage BLANK_n=1, and address < H_ACTIVE*V_ACTIVE.
REQ-026 SHALL present oWR_EN/oWR_ADDR/oWR_DATA registered, 2 cycles after pins (input stage + output stage).
REQ-027 SHALL drop (not write) an active pixel coincident with frame start; frame start takes priority.
REQ-028 SHALL set oOVF when an active pixel arrives at address >= H_ACTIVE*V_ACTIVE while LOCKED, hold it until next frame start, and suppress the write.

Reset
REQ-029 SHALL, on iRST, asynchronously force state SEARCH, all counters and address 0, all outputs 0.
REQ-030 SHALL, on reset mid-frame, discard that frame and restart at the next frame start.

Configuration
REQ-031 SHALL, with VGA_CAPTURE_MEASURE_EN defined, add outputs oH_ACTIVE[10:0], oV_ACTIVE[10:0], oH_TOTAL[10:0] (clocks between line starts), updated at each frame start, reset 0.
REQ-032 SHALL, without VGA_CAPTURE_MEASURE_EN, omit those ports and the H_TOTAL counter; all other behaviour identical.

Structure
REQ-033 SHALL place FSM state typedef, counter widths and address width in shared package vga_pkg.
REQ-034 SHALL implement sync edge detection plus width/height measurement in sub-module vga_timing_meas.

Verification
REQ-035 SHALL cover: 640x480 stream from the team's sync generator -> oLOCK high after frame start 3; first write address 0, last 307199.
REQ-036 SHALL cover: one frame with 639 active pixels on one line after lock -> oLOCK low at the next frame start, relock after 2 good frames.
REQ-037 SHALL cover: 481 active lines while LOCKED -> oOVF high during line 481, no write at address 307200; oLOCK drops at next frame start.
REQ-038 SHALL cover: iRST pulse mid-line -> all outputs 0 same cycle; no writes until relock.
REQ-039 SHALL cover: pixel 0x5A3 at pin cycle N with lock -> oWR_DATA=0x5A3, oWR_EN=1 at cycle N+2.
REQ-040 SHALL cover: with VGA_CAPTURE_MEASURE_EN, 800-clock lines -> oH_TOTAL=800, oH_ACTIVE=640, oV_ACTIVE=480.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types, widths and helpers for the VGA capture block
//
// Purpose : capture FSM state type, measurement counter width, frame-buffer
//           address width and a saturating increment helper.
// Ports   : none (package).
// Config  : VGA_CAPTURE_MEASURE_EN (see vga_capture.sv) uses CNT_W for the
//           extra measurement outputs.

package vga_pkg;

  localparam int CNT_W   = 11;  // width/height/h-total counters
  localparam int ADDR_W  = 19;  // frame-buffer write address
  localparam int PIX_W   = 12;  // {B,G,R} 4 bits each
  localparam int MATCH_W = 8;   // consecutive matching frames

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Counters stick at all-ones rather than wrapping, so an absurdly long
  // line or frame can never alias back onto the expected geometry.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_timing_meas.sv
// rtl/vga_timing_meas.sv - sync edge detection and active-area measurement
//
// Purpose : detects frame start (VS fall) and line start (HS fall) from the
//           already-registered sync inputs, and measures per frame the
//           active width of the most recent line and the number of lines
//           holding at least one active pixel. Counters saturate at 2047.
// Ports   : i_clk, i_rst          clock, async active-high reset
//           i_hs, i_vs, i_de      input-stage HS/VS (active-low), data enable
//           o_frame_start         combinational VS-fall strobe
//           o_width, o_height     measurements of the frame in progress
//           o_htotal              clocks between line starts
//                                 (only with VGA_CAPTURE_MEASURE_EN)

module vga_timing_meas
  import vga_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hs,
  input  logic             i_vs,
  input  logic             i_de,
  output logic             o_frame_start,
  output logic [CNT_W-1:0] o_width,
  output logic [CNT_W-1:0] o_height
`ifdef VGA_CAPTURE_MEASURE_EN
  ,
  output logic [CNT_W-1:0] o_htotal
`endif
);

  logic             r_hs_d;
  logic             r_vs_d;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_height;
  logic             w_line_start;
  logic [CNT_W-1:0] w_pix_base;

  // Previous values reset low, so a sync already low when reset releases
  // cannot fake an edge; a fall is only seen after a high has been observed.
  assign o_frame_start = r_vs_d & ~i_vs;
  assign w_line_start  = r_hs_d & ~i_hs;
  // A pixel arriving together with the line start is the first of its line.
  assign w_pix_base    = w_line_start ? '0 : r_pix_cnt;

  assign o_width  = r_width;
  assign o_height = r_height;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hs_d    <= 1'b0;
      r_vs_d    <= 1'b0;
      r_pix_cnt <= '0;
      r_width   <= '0;
      r_height  <= '0;
    end else begin
      r_hs_d <= i_hs;
      r_vs_d <= i_vs;
      if (o_frame_start) begin
        r_pix_cnt <= '0;
        r_width   <= '0;
        r_height  <= '0;
      end else if (i_de) begin
        r_pix_cnt <= sat_inc(w_pix_base);
        // Tracking every pixel leaves the line's final count in place once
        // its last active pixel has passed.
        r_width   <= sat_inc(w_pix_base);
        if (w_pix_base == '0) begin
          r_height <= sat_inc(r_height);
        end
      end else if (w_line_start) begin
        r_pix_cnt <= '0;
      end
    end
  end

`ifdef VGA_CAPTURE_MEASURE_EN
  logic [CNT_W-1:0] r_clk_cnt;
  logic [CNT_W-1:0] r_htotal;

  // r_clk_cnt holds (period - 1) when the next line start arrives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_cnt <= '0;
      r_htotal  <= '0;
    end else if (w_line_start) begin
      r_clk_cnt <= '0;
      r_htotal  <= sat_inc(r_clk_cnt);
    end else begin
      r_clk_cnt <= sat_inc(r_clk_cnt);
    end
  end

  assign o_htotal = r_htotal;
`endif

endmodule

// File: rtl/vga_capture.sv
// rtl/vga_capture.sv - VGA stream capture into a frame buffer with timing lock
//
// Purpose : registers the VGA pins, measures frame geometry, locks after
//           LOCK_FRAMES consecutive frames of H_ACTIVE x V_ACTIVE, and while
//           locked writes each active pixel to a linear frame-buffer address.
// Ports   : iVGA_CLK, iRST        pixel clock, async active-high reset
//           iHS, iVS              syncs, active-low
//           iBLANK_n              data enable, high = active pixel
//           iVGA_R/G/B            4-bit colour
//           oWR_EN/ADDR/DATA      frame-buffer write, {B,G,R} data, 2 cycles
//                                 after the pins
//           oLOCK                 high while locked
//           oFRAME_START          one-cycle pulse per detected frame
//           oOVF                  write past frame-buffer end, held per frame
//           oH_ACTIVE/oV_ACTIVE/oH_TOTAL  measured geometry, updated at each
//                                 frame start (only with VGA_CAPTURE_MEASURE_EN)

module vga_capture
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              iVGA_CLK,
  input  logic              iRST,
  input  logic              iHS,
  input  logic              iVS,
  input  logic              iBLANK_n,
  input  logic [3:0]        iVGA_R,
  input  logic [3:0]        iVGA_G,
  input  logic [3:0]        iVGA_B,
  output logic              oWR_EN,
  output logic [ADDR_W-1:0] oWR_ADDR,
  output logic [PIX_W-1:0]  oWR_DATA,
  output logic              oLOCK,
  output logic              oFRAME_START,
  output logic              oOVF
`ifdef VGA_CAPTURE_MEASURE_EN
  ,
  output logic [CNT_W-1:0]  oH_ACTIVE,
  output logic [CNT_W-1:0]  oV_ACTIVE,
  output logic [CNT_W-1:0]  oH_TOTAL
`endif
);

  localparam logic [ADDR_W-1:0]  FB_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [CNT_W-1:0]   H_EXP   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]   V_EXP   = CNT_W'(V_ACTIVE);
  localparam logic [MATCH_W-1:0] LOCK_N  = MATCH_W'(LOCK_FRAMES);

  // Input stage
  logic             r_hs;
  logic             r_vs;
  logic             r_de;
  logic [PIX_W-1:0] r_rgb;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_de  <= 1'b0;
      r_rgb <= '0;
    end else begin
      r_hs  <= iHS;
      r_vs  <= iVS;
      r_de  <= iBLANK_n;
      r_rgb <= {iVGA_B, iVGA_G, iVGA_R};
    end
  end

  logic             w_frame_start;
  logic [CNT_W-1:0] w_width;
  logic [CNT_W-1:0] w_height;
`ifdef VGA_CAPTURE_MEASURE_EN
  logic [CNT_W-1:0] w_htotal;
`endif

  vga_timing_meas u_meas (
    .i_clk         (iVGA_CLK),
    .i_rst         (iRST),
    .i_hs          (r_hs),
    .i_vs          (r_vs),
    .i_de          (r_de),
    .o_frame_start (w_frame_start),
    .o_width       (w_width),
    .o_height      (w_height)
`ifdef VGA_CAPTURE_MEASURE_EN
    ,
    .o_htotal      (w_htotal)
`endif
  );

  // Lock FSM: decisions are only taken at frame start, on the geometry of
  // the frame that has just ended.
  state_t             r_state;
  state_t             w_state_next;
  logic [MATCH_W-1:0] r_match;
  logic [MATCH_W-1:0] w_match_next;
  logic               w_geom_ok;

  assign w_geom_ok = (w_width == H_EXP) && (w_height == V_EXP);

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_state <= ST_SEARCH;
      r_match <= '0;
    end else begin
      r_state <= w_state_next;
      r_match <= w_match_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_match_next = r_match;
    if (w_frame_start) begin
      unique case (r_state)
        ST_SEARCH: begin
          // The frame before the first detected start is partial; no compare.
          w_state_next = ST_MEASURE;
        end
        ST_MEASURE: begin
          if (w_geom_ok) begin
            w_match_next = r_match + MATCH_W'(1);
            if (w_match_next >= LOCK_N) begin
              w_state_next = ST_LOCKED;
            end
          end else begin
            w_match_next = '0;
          end
        end
        ST_LOCKED: begin
          if (!w_geom_ok) begin
            w_state_next = ST_SEARCH;
            w_match_next = '0;
          end
        end
        default: begin
          w_state_next = ST_SEARCH;
          w_match_next = '0;
        end
      endcase
    end
  end

  // Write path: address counts written pixels of the current frame.
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [PIX_W-1:0]  r_wr_data;
  logic              r_frame_start;
  logic              r_ovf;
  logic              w_locked;
  logic              w_in_range;
  logic              w_wr;

  assign w_locked   = (r_state == ST_LOCKED);
  assign w_in_range = (r_addr < FB_SIZE);
  // Frame start wins over a coincident active pixel, which is dropped.
  assign w_wr       = w_locked & r_de & ~w_frame_start & w_in_range;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_addr        <= '0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_start <= 1'b0;
      r_ovf         <= 1'b0;
    end else begin
      r_frame_start <= w_frame_start;
      r_wr_en       <= w_wr;
      if (w_wr) begin
        r_wr_addr <= r_addr;
        r_wr_data <= r_rgb;
      end
      if (w_frame_start) begin
        r_addr <= '0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_wr) begin
          r_addr <= r_addr + ADDR_W'(1);
        end
        if (w_locked && r_de && !w_in_range) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign oWR_EN       = r_wr_en;
  assign oWR_ADDR     = r_wr_addr;
  assign oWR_DATA     = r_wr_data;
  assign oFRAME_START = r_frame_start;
  assign oOVF         = r_ovf;
  assign oLOCK        = w_locked;

`ifdef VGA_CAPTURE_MEASURE_EN
  logic [CNT_W-1:0] r_h_active;
  logic [CNT_W-1:0] r_v_active;
  logic [CNT_W-1:0] r_h_total;

  always_ff @(posedge iVGA_CLK or posedge iRST) begin
    if (iRST) begin
      r_h_active <= '0;
      r_v_active <= '0;
      r_h_total  <= '0;
    end else if (w_frame_start) begin
      r_h_active <= w_width;
      r_v_active <= w_height;
      r_h_total  <= w_htotal;
    end
  end

  assign oH_ACTIVE = r_h_active;
  assign oV_ACTIVE = r_v_active;
  assign oH_TOTAL  = r_h_total;
`endif

endmodule

// File: tb/tb_vga_capture.sv
// tb/tb_vga_capture.sv - self-checking bench for vga_capture (scaled geometry)

module tb_vga_capture;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int LF   = 2;
  localparam int HTOT = 14;
  localparam int VTOT = 8;
  localparam int SIZE = H * V;
  localparam int NEXP = 4096;
  localparam int NFR  = 17;
  localparam int M_SEARCH = 0, M_MEASURE = 1, M_LOCKED = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b1, vs = 1'b1, de = 1'b0;
  logic [3:0]  pr = '0, pg = '0, pb = '0;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [11:0] wr_data;
  logic        lock, fs, ovf;
`ifdef VGA_CAPTURE_MEASURE_EN
  logic [10:0] h_act, v_act, h_tot;
`endif

  vga_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LF)) dut (
    .iVGA_CLK     (clk),
    .iRST         (rst),
    .iHS          (hs),
    .iVS          (vs),
    .iBLANK_n     (de),
    .iVGA_R       (pr),
    .iVGA_G       (pg),
    .iVGA_B       (pb),
    .oWR_EN       (wr_en),
    .oWR_ADDR     (wr_addr),
    .oWR_DATA     (wr_data),
    .oLOCK        (lock),
    .oFRAME_START (fs),
    .oOVF         (ovf)
`ifdef VGA_CAPTURE_MEASURE_EN
    ,
    .oH_ACTIVE    (h_act),
    .oV_ACTIVE    (v_act),
    .oH_TOTAL     (h_tot)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs indexed by the posedge count at which they are sampled.
  bit        exp_en   [NEXP];
  bit [18:0] exp_addr [NEXP];
  bit [11:0] exp_data [NEXP];
  bit        exp_lock [NEXP];
  bit        exp_fs   [NEXP];
  bit        exp_ovf  [NEXP];

  int total = 0;
  int bad   = 0;

  task automatic check(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Observation statistics gathered by the compare process.
  int wr_count = 0, max_addr = -1, oob_count = 0, ovf_seen = 0;
  int first_wr_cyc = -1, first_wr_addr = -1, first_wr_data = -1;

  always @(negedge clk) begin
    if (cyc < NEXP) begin
      check("wr_en", int'(wr_en), int'(exp_en[cyc]));
      if (exp_en[cyc]) begin
        check("wr_addr", int'(wr_addr), int'(exp_addr[cyc]));
        check("wr_data", int'(wr_data), int'(exp_data[cyc]));
      end
      check("lock", int'(lock), int'(exp_lock[cyc]));
      check("frame_start", int'(fs), int'(exp_fs[cyc]));
      check("ovf", int'(ovf), int'(exp_ovf[cyc]));
    end
    if (wr_en) begin
      wr_count++;
      if (first_wr_cyc < 0) begin
        first_wr_cyc  = cyc;
        first_wr_addr = int'(wr_addr);
        first_wr_data = int'(wr_data);
      end
      if (int'(wr_addr) > max_addr) max_addr = int'(wr_addr);
      if (int'(wr_addr) >= SIZE) oob_count++;
    end
    if (ovf) ovf_seen = 1;
  end

  // Frame-level model: geometry of the last complete frame, lock state,
  // active-pixel index within the current frame.
  int m_state = M_SEARCH, m_match = 0, m_pix = 0, m_ovf = 0;
  int m_last_w = 0, m_last_h = 0;
  bit m_prev_vs = 1'b0;
  int wr_at_rst = 0;
  int t_mark = -1;

  task automatic drive_cycle(bit h, bit v, bit d, bit [11:0] px, bit rst_now);
    int idx;
    bit was_rst;
    bit ok;
    idx = cyc + 2;
    was_rst = rst;
    hs = h; vs = v; de = d;
    pb = px[11:8]; pg = px[7:4]; pr = px[3:0];
    rst = rst_now;
    if (rst_now) begin
      m_state = M_SEARCH; m_match = 0; m_ovf = 0; m_pix = 0; m_prev_vs = 1'b0;
      for (int k = idx - 1; k <= idx; k++) begin
        exp_en[k] = 0; exp_lock[k] = 0; exp_fs[k] = 0; exp_ovf[k] = 0;
      end
      if (!was_rst) begin
        wr_at_rst = wr_count;
        #1;
        check("rst_now_wr_en", int'(wr_en), 0);
        check("rst_now_lock", int'(lock), 0);
        check("rst_now_fs", int'(fs), 0);
        check("rst_now_ovf", int'(ovf), 0);
        check("rst_now_addr", int'(wr_addr), 0);
        check("rst_now_data", int'(wr_data), 0);
      end
      return;
    end
    if (m_prev_vs && !v) begin
      ok = (m_last_w == H) && (m_last_h == V);
      case (m_state)
        M_SEARCH:  m_state = M_MEASURE;
        M_MEASURE: begin
          if (ok) begin
            m_match++;
            if (m_match >= LF) m_state = M_LOCKED;
          end else begin
            m_match = 0;
          end
        end
        default: begin
          if (!ok) begin
            m_state = M_SEARCH;
            m_match = 0;
          end
        end
      endcase
      m_pix = 0;
      m_ovf = 0;
      exp_fs[idx] = 1;
    end else if (d) begin
      if (m_state == M_LOCKED) begin
        if (m_pix < SIZE) begin
          exp_en[idx]   = 1;
          exp_addr[idx] = 19'(m_pix);
          exp_data[idx] = px;
        end else begin
          m_ovf = 1;
        end
      end
      m_pix++;
    end
    exp_lock[idx] = (m_state == M_LOCKED);
    exp_ovf[idx]  = (m_ovf != 0);
    m_prev_vs = v;
  endtask

  task automatic idle(int n, bit rst_now);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      drive_cycle(1'b1, 1'b1, 1'b0, 12'h000, rst_now);
    end
  endtask

  // Active lines start at line 2, active pixels at column 4; the last active
  // line carries last_len pixels.
  task automatic send_frame(int nlines, int last_len, int rst_line, int rst_col, bit [11:0] mark_px);
    for (int l = 0; l < VTOT; l++) begin
      for (int c = 0; c < HTOT; c++) begin
        bit h_, v_, d_, r_;
        bit [11:0] px;
        int len;
        h_  = (c >= 2);
        v_  = (l != 0);
        len = (l == 2 + nlines - 1) ? last_len : H;
        d_  = (l >= 2) && (l < 2 + nlines) && (c >= 4) && (c < 4 + len);
        r_  = (l == rst_line) && ((c == rst_col) || (c == rst_col + 1));
        px  = 12'($urandom);
        @(negedge clk); #1;
        if (mark_px != 12'h000 && l == 2 && c == 4) begin
          px = mark_px;
          t_mark = cyc;
        end
        drive_cycle(h_, v_, d_, px, r_);
      end
    end
    m_last_w = last_len;
    m_last_h = nlines;
  endtask

  int fr_lines [NFR] = '{4, 4, 4, 4, 4, 4, 4, 4, 5, 4, 4, 4, 4, 4, 4, 4, 4};
  int fr_last  [NFR] = '{8, 8, 8, 8, 7, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
  int lock_tab [NFR] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1};

  initial begin
    int w0;
    idle(3, 1'b1);
    check("reset_lock", int'(lock), 0);
    check("reset_wr_en", int'(wr_en), 0);
    check("reset_ovf", int'(ovf), 0);
    idle(3, 1'b0);
    for (int f = 0; f < NFR; f++) begin
      w0 = wr_count;
      max_addr = -1;
      ovf_seen = 0;
      send_frame(fr_lines[f], fr_last[f], (f == 12) ? 3 : -1, 6,
                 (f == 2) ? 12'h5A3 : 12'h000);
      check($sformatf("lock_end_frame%0d", f + 1), int'(lock), lock_tab[f]);
      if (f == 2) begin
        check("first_wr_cycle", first_wr_cyc, t_mark + 2);
        check("first_wr_addr", first_wr_addr, 0);
        check("first_wr_data", first_wr_data, 'h5A3);
        check("f3_writes", wr_count - w0, 32);
        check("f3_last_addr", max_addr, 31);
      end
      if (f == 3) check("f4_no_ovf", ovf_seen, 0);
      if (f == 4) begin
        check("short_frame_writes", wr_count - w0, 31);
        check("short_frame_last_addr", max_addr, 30);
      end
      if (f == 8) begin
        check("tall_frame_writes", wr_count - w0, 32);
        check("tall_frame_last_addr", max_addr, 31);
        check("tall_frame_ovf_seen", ovf_seen, 1);
        check("tall_frame_ovf_held", int'(ovf), 1);
      end
      if (f == 14) check("no_writes_after_reset", wr_count, wr_at_rst);
      if (f == 15) check("relock_writes", wr_count - w0, 32);
`ifdef VGA_CAPTURE_MEASURE_EN
      if (f == 3) begin
        check("h_active", int'(h_act), 8);
        check("v_active", int'(v_act), 4);
        check("h_total", int'(h_tot), 14);
      end
      if (f == 5) check("h_active_short", int'(h_act), 7);
`endif
    end
    idle(4, 1'b0);
    check("no_out_of_range_write", oob_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
